// File: rtl/ysyx_24100012_regfile_pkg.sv
// Shared types and defaults for the NPC integer register file and its busy scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ysyx_24100012_regfile_pkg;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_N_REG      = 32;
   localparam int RF_INDEX_LEN  = 5;

   typedef logic [RF_INDEX_LEN-1:0]  reg_idx_t;
   typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

   localparam reg_idx_t REG_ZERO = '0;

   // Index addresses a real register (x0 included).
   function automatic logic idx_in_range(input int idx, input int n_reg);
      return (idx < n_reg);
   endfunction

   // Index addresses a register that can hold a value (x0 excluded).
   function automatic logic idx_writable(input int idx, input int n_reg);
      return (idx != int'(REG_ZERO)) && (idx < n_reg);
   endfunction

endpackage

// File: rtl/ysyx_24100012_regfile_sb_if.sv
// Bundle between decode/issue + writeback (master) and the register file (slave).
// Latency: wires only; read/claim results are combinational, state updates land on the next edge.
// Backpressure: a claim is refused through claim_ok; reads and writes are never stalled.
// Signals: wr_en/wr_idx/wr_data (packed per write port), rd_idx -> rd_data/rd_busy
//          (packed per read port), claim_en/claim_idx -> claim_ok, busy_vec.
interface ysyx_24100012_regfile_sb_if
   import ysyx_24100012_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int N_REG      = RF_N_REG,
   parameter int INDEX_LEN  = RF_INDEX_LEN,
   parameter int N_RD       = 2,
   parameter int N_WR       = 2
);
   logic [N_WR-1:0]            wr_en;
   logic [N_WR*INDEX_LEN-1:0]  wr_idx;
   logic [N_WR*DATA_WIDTH-1:0] wr_data;
   logic [N_RD*INDEX_LEN-1:0]  rd_idx;
   logic [N_RD*DATA_WIDTH-1:0] rd_data;
   logic [N_RD-1:0]            rd_busy;
   logic                       claim_en;
   logic [INDEX_LEN-1:0]       claim_idx;
   logic                       claim_ok;
   logic [N_REG-1:0]           busy_vec;

   modport master (
      output wr_en, wr_idx, wr_data, rd_idx, claim_en, claim_idx,
      input  rd_data, rd_busy, claim_ok, busy_vec
   );

   modport slave (
      input  wr_en, wr_idx, wr_data, rd_idx, claim_en, claim_idx,
      output rd_data, rd_busy, claim_ok, busy_vec
   );
endinterface

// File: rtl/ysyx_24100012_scoreboard.sv
// Per-register busy scoreboard: decode claims a destination, writeback releases it.
// Latency: claim_ok combinational; busy bits update at the next clock edge.
// Backpressure: a claim on a busy register is refused (claim_ok=0); the requester must retry.
// Ports: clk, rst (sync, active-high), claim_en_i/claim_idx_i -> claim_ok_o,
//        rel_vec_i (one-hot-per-register release mask), busy_vec_o (registered, bit 0 always 0).
module ysyx_24100012_scoreboard
   import ysyx_24100012_regfile_pkg::*;
#(
   parameter int N_REG     = RF_N_REG,
   parameter int INDEX_LEN = RF_INDEX_LEN
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 claim_en_i,
   input  logic [INDEX_LEN-1:0] claim_idx_i,
   input  logic [N_REG-1:0]     rel_vec_i,
   output logic                 claim_ok_o,
   output logic [N_REG-1:0]     busy_vec_o
);

   logic [N_REG-1:0] busy_q;
   logic [N_REG-1:0] busy_d;
   logic             claim_busy;

   // Lookup by scan so an out-of-range index simply reads as not busy.
   always_comb begin
      claim_busy = 1'b0;
      for (int r = 0; r < N_REG; r++) begin
         if (int'(claim_idx_i) == r) claim_busy = busy_q[r];
      end
   end

   assign claim_ok_o = claim_en_i & ~rst & ~claim_busy
                     & idx_in_range(int'(claim_idx_i), N_REG);

   // Release first, then set: an accepted claim overrides a same-cycle release.
   // A refused claim leaves the release alone, so a busy register clears.
   always_comb begin
      busy_d = busy_q & ~rel_vec_i;
      for (int r = 1; r < N_REG; r++) begin
         if (claim_ok_o && int'(claim_idx_i) == r) busy_d[r] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_vec_o = busy_q;

endmodule

// File: rtl/ysyx_24100012_regfile_sb.sv
// Multi-port integer register file (x0 reads zero) with a per-register busy scoreboard.
// Latency: reads combinational; writes visible the cycle after the edge (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none on reads/writes; claims are refused while the target is busy or during reset.
// Ports: clk, rst (sync, active-high), bus (slave modport of ysyx_24100012_regfile_sb_if).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module ysyx_24100012_regfile_sb
   import ysyx_24100012_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int N_REG      = RF_N_REG,
   parameter int INDEX_LEN  = RF_INDEX_LEN,
   parameter int N_RD       = 2,
   parameter int N_WR       = 2
)(
   input  logic                      clk,
   input  logic                      rst,
   ysyx_24100012_regfile_sb_if.slave bus
);

   logic [DATA_WIDTH-1:0] regs_q [N_REG];
   logic [DATA_WIDTH-1:0] regs_d [N_REG];

   logic [INDEX_LEN-1:0]  wr_idx_a  [N_WR];
   logic [DATA_WIDTH-1:0] wr_data_a [N_WR];
   logic [N_WR-1:0]       wr_vld;
   logic [INDEX_LEN-1:0]  rd_idx_a  [N_RD];
   logic [DATA_WIDTH-1:0] rd_data_a [N_RD];
   logic [N_RD-1:0]       rd_busy_a;
   logic [N_REG-1:0]      rel_vec;
   logic [N_REG-1:0]      busy_vec;

   // Unpack the flat port buses.
   for (genvar k = 0; k < N_WR; k++) begin : g_wr_unpack
      assign wr_idx_a[k]  = bus.wr_idx[k*INDEX_LEN +: INDEX_LEN];
      assign wr_data_a[k] = bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      assign wr_vld[k]    = bus.wr_en[k] & idx_writable(int'(bus.wr_idx[k*INDEX_LEN +: INDEX_LEN]), N_REG);
   end

   for (genvar p = 0; p < N_RD; p++) begin : g_rd_pack
      assign rd_idx_a[p] = bus.rd_idx[p*INDEX_LEN +: INDEX_LEN];
      assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_a[p];
   end
   assign bus.rd_busy = rd_busy_a;

   // Ports are walked in ascending order so the highest-numbered enabled port wins.
   // Every valid write also produces a release for the scoreboard.
   always_comb begin
      rel_vec = '0;
      for (int r = 0; r < N_REG; r++) regs_d[r] = regs_q[r];
      for (int k = 0; k < N_WR; k++) begin
         for (int r = 1; r < N_REG; r++) begin
            if (wr_vld[k] && int'(wr_idx_a[k]) == r) begin
               regs_d[r]  = wr_data_a[k];
               rel_vec[r] = 1'b1;
            end
         end
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < N_REG; r++) regs_q[r] <= '0;
      end else begin
         for (int r = 0; r < N_REG; r++) regs_q[r] <= regs_d[r];
      end
   end

   // regs_q[0] and busy_vec[0] are held at zero, so x0 needs no special case here;
   // an index beyond N_REG matches nothing and keeps the zero default.
   always_comb begin
      for (int p = 0; p < N_RD; p++) begin
         rd_data_a[p] = '0;
         rd_busy_a[p] = 1'b0;
         for (int r = 0; r < N_REG; r++) begin
            if (int'(rd_idx_a[p]) == r) begin
               rd_data_a[p] = regs_q[r];
               rd_busy_a[p] = busy_vec[r];
            end
         end
`ifdef REGFILE_BYPASS_EN
         // Writes are dropped during reset, so nothing is forwarded then either.
         for (int k = 0; k < N_WR; k++) begin
            if (!rst && wr_vld[k] && wr_idx_a[k] == rd_idx_a[p]) begin
               rd_data_a[p] = wr_data_a[k];
               rd_busy_a[p] = 1'b0;
            end
         end
`endif
      end
   end

   ysyx_24100012_scoreboard #(
      .N_REG     (N_REG),
      .INDEX_LEN (INDEX_LEN)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .claim_en_i  (bus.claim_en),
      .claim_idx_i (bus.claim_idx),
      .rel_vec_i   (rel_vec),
      .claim_ok_o  (bus.claim_ok),
      .busy_vec_o  (busy_vec)
   );

   assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_ysyx_24100012_regfile_sb.sv
// Self-checking bench for ysyx_24100012_regfile_sb: directed scenarios then random traffic
// against an array-based reference model. Honours REGFILE_BYPASS_EN like the design.
module tb_ysyx_24100012_regfile_sb;

   localparam int DW  = 32;
   localparam int NR  = 32;
   localparam int IL  = 5;
   localparam int NRD = 2;
   localparam int NWR = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_24100012_regfile_sb_if #(
      .DATA_WIDTH(DW), .N_REG(NR), .INDEX_LEN(IL), .N_RD(NRD), .N_WR(NWR)
   ) bus ();

   ysyx_24100012_regfile_sb #(
      .DATA_WIDTH(DW), .N_REG(NR), .INDEX_LEN(IL), .N_RD(NRD), .N_WR(NWR)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Architectural view: register values and outstanding destinations.
   logic [DW-1:0] m_regs [NR];
   logic          m_busy [NR];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [IL-1:0] rd_idx_of(input int p);
      return bus.rd_idx[p*IL +: IL];
   endfunction

   function automatic logic [DW-1:0] rd_data_of(input int p);
      return bus.rd_data[p*DW +: DW];
   endfunction

   function automatic logic exp_claim_ok();
      return bus.claim_en && !rst && !m_busy[bus.claim_idx];
   endfunction

   // A write port counts only if enabled and aimed at x1..x31 while out of reset.
   function automatic logic wr_counts(input int k);
      return !rst && bus.wr_en[k] && (bus.wr_idx[k*IL +: IL] != 5'd0);
   endfunction

   function automatic logic [DW-1:0] exp_rd_data(input int p);
      logic [IL-1:0] idx;
      logic [DW-1:0] v;
      idx = rd_idx_of(p);
      v   = (idx == 5'd0) ? 32'd0 : m_regs[idx];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++)
         if (wr_counts(k) && bus.wr_idx[k*IL +: IL] == idx) v = bus.wr_data[k*DW +: DW];
`endif
      return v;
   endfunction

   function automatic logic exp_rd_busy(input int p);
      logic [IL-1:0] idx;
      logic b;
      idx = rd_idx_of(p);
      b   = (idx == 5'd0) ? 1'b0 : m_busy[idx];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++)
         if (wr_counts(k) && bus.wr_idx[k*IL +: IL] == idx) b = 1'b0;
`endif
      return b;
   endfunction

   function automatic logic [NR-1:0] exp_busy_vec();
      logic [NR-1:0] v;
      for (int r = 0; r < NR; r++) v[r] = m_busy[r];
      return v;
   endfunction

   task automatic check_all(input string tag);
      for (int p = 0; p < NRD; p++) begin
         check($sformatf("%s.rd_data%0d", tag, p), 64'(rd_data_of(p)), 64'(exp_rd_data(p)));
         check($sformatf("%s.rd_busy%0d", tag, p), 64'(bus.rd_busy[p]), 64'(exp_rd_busy(p)));
      end
      check($sformatf("%s.claim_ok", tag), 64'(bus.claim_ok), 64'(exp_claim_ok()));
      check($sformatf("%s.busy_vec", tag), 64'(bus.busy_vec), 64'(exp_busy_vec()));
   endtask

   // Advance one clock and move the model to the state the current inputs imply.
   task automatic tick();
      logic [DW-1:0] n_regs [NR];
      logic          n_busy [NR];
      logic          ok;
      ok = exp_claim_ok();
      for (int r = 0; r < NR; r++) begin
         n_regs[r] = rst ? 32'd0 : m_regs[r];
         n_busy[r] = rst ? 1'b0  : m_busy[r];
      end
      for (int k = 0; k < NWR; k++) begin
         if (wr_counts(k)) begin
            n_regs[bus.wr_idx[k*IL +: IL]] = bus.wr_data[k*DW +: DW];
            n_busy[bus.wr_idx[k*IL +: IL]] = 1'b0;
         end
      end
      if (ok && bus.claim_idx != 5'd0) n_busy[bus.claim_idx] = 1'b1;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
         m_regs[r] = n_regs[r];
         m_busy[r] = n_busy[r];
      end
   endtask

   task automatic idle();
      rst           = 1'b0;
      bus.wr_en     = '0;
      bus.wr_idx    = '0;
      bus.wr_data   = '0;
      bus.rd_idx    = '0;
      bus.claim_en  = 1'b0;
      bus.claim_idx = '0;
   endtask

   task automatic wr(input int k, input logic [IL-1:0] idx, input logic [DW-1:0] data);
      bus.wr_en[k]             = 1'b1;
      bus.wr_idx[k*IL +: IL]   = idx;
      bus.wr_data[k*DW +: DW]  = data;
   endtask

   task automatic rd(input int p, input logic [IL-1:0] idx);
      bus.rd_idx[p*IL +: IL] = idx;
   endtask

   task automatic claim(input logic [IL-1:0] idx);
      bus.claim_en  = 1'b1;
      bus.claim_idx = idx;
   endtask

   initial begin
      for (int r = 0; r < NR; r++) begin
         m_regs[r] = '0;
         m_busy[r] = 1'b0;
      end
      idle();
      rst = 1'b1;
      #1;
      tick();
      idle();
      #1;
      check("init.busy_vec", 64'(bus.busy_vec), 64'd0);
      check_all("init");

      // 1. reset clears data and busy; claims refused during reset
      wr(0, 5'd5, 32'hDEAD);
      claim(5'd5);
      #1; check_all("t1.wr");
      tick();
      idle(); rd(0, 5'd5);
      #1;
      check("t1.x5_written", 64'(rd_data_of(0)), 64'hDEAD);
      check("t1.x5_busy", 64'(bus.busy_vec[5]), 64'd1);
      rst = 1'b1; claim(5'd6); wr(1, 5'd6, 32'h1234);
      #1;
      check("t1.claim_in_rst", 64'(bus.claim_ok), 64'd0);
      check_all("t1.rst");
      tick();
      idle(); rd(0, 5'd5); rd(1, 5'd6);
      #1;
      check("t1.x5_after_rst", 64'(rd_data_of(0)), 64'd0);
      check("t1.x6_after_rst", 64'(rd_data_of(1)), 64'd0);
      check("t1.busy_after_rst", 64'(bus.busy_vec), 64'd0);

      // 2. x0 ignores writes; claim of x0 accepted without effect
      idle(); wr(0, 5'd0, 32'hFFFF_FFFF); rd(0, 5'd0);
      #1; check_all("t2.wr");
      tick();
      idle(); rd(0, 5'd0); claim(5'd0);
      #1;
      check("t2.x0_read", 64'(rd_data_of(0)), 64'd0);
      check("t2.claim_x0", 64'(bus.claim_ok), 64'd1);
      tick();
      idle();
      #1;
      check("t2.busy0", 64'(bus.busy_vec[0]), 64'd0);

      // 3. both ports write x3: port 1 wins
      idle(); wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); rd(1, 5'd3);
      #1; check_all("t3.wr");
      tick();
      idle(); rd(1, 5'd3);
      #1;
      check("t3.x3", 64'(rd_data_of(1)), 64'h22);

      // 4. claim, refused reclaim, release by write
      idle(); claim(5'd7);
      #1; check("t4.claim1", 64'(bus.claim_ok), 64'd1);
      tick();
      idle(); claim(5'd7); rd(0, 5'd7);
      #1;
      check("t4.busy7_set", 64'(bus.busy_vec[7]), 64'd1);
      check("t4.rd_busy7", 64'(bus.rd_busy[0]), 64'd1);
      check("t4.claim2", 64'(bus.claim_ok), 64'd0);
      tick();
      idle(); wr(0, 5'd7, 32'h5); rd(0, 5'd7);
      #1; check_all("t4.release");
      tick();
      idle(); rd(0, 5'd7);
      #1;
      check("t4.busy7_clr", 64'(bus.busy_vec[7]), 64'd0);
      check("t4.x7", 64'(rd_data_of(0)), 64'h5);

      // 5. same-cycle claim + release of x9
      idle(); claim(5'd9); wr(1, 5'd9, 32'h99);
      #1; check("t5.claim_free", 64'(bus.claim_ok), 64'd1);
      tick();
      idle();
      #1; check("t5.busy9_set", 64'(bus.busy_vec[9]), 64'd1);
      claim(5'd9); wr(0, 5'd9, 32'h98);
      #1; check("t5.claim_busy", 64'(bus.claim_ok), 64'd0);
      tick();
      idle();
      #1; check("t5.busy9_clr", 64'(bus.busy_vec[9]), 64'd0);

      // 6. write-to-read latency on x4
      idle(); wr(0, 5'd4, 32'h1111);
      tick();
      idle(); wr(1, 5'd4, 32'hABCD); rd(0, 5'd4);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("t6.same_cycle", 64'(rd_data_of(0)), 64'hABCD);
`else
      check("t6.same_cycle", 64'(rd_data_of(0)), 64'h1111);
`endif
      check_all("t6.wr");
      tick();
      idle(); rd(0, 5'd4);
      #1;
      check("t6.next_cycle", 64'(rd_data_of(0)), 64'hABCD);

      // Random traffic on a narrow index range to force collisions and busy hits.
      for (int i = 0; i < 400; i++) begin
         idle();
         rst = ($urandom_range(0, 49) == 0);
         for (int k = 0; k < NWR; k++) begin
            bus.wr_en[k]            = 1'($urandom_range(0, 1));
            bus.wr_idx[k*IL +: IL]  = 5'($urandom_range(0, 15));
            bus.wr_data[k*DW +: DW] = $urandom;
         end
         for (int p = 0; p < NRD; p++) rd(p, 5'($urandom_range(0, 15)));
         bus.claim_en  = 1'($urandom_range(0, 1));
         bus.claim_idx = 5'($urandom_range(0, 15));
         #1;
         check_all($sformatf("rnd%0d", i));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
